// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch responder between the PC and instruction memory.
// Issues one word read per accepted PC address (at most one outstanding), queues
// returned words with their PCs in a small FIFO, and exposes the head instruction's
// decode fields back to the PC's jump/branch logic.
// Optional feature macro: IFETCH_BYPASS_EN (same-cycle presentation of returning data
// when the FIFO is empty).
module ifetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              redirect,
  output logic              pc_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_instr,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [5:0]        op,
  output logic [15:0]       offset,
  output logic [25:0]       target
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic full, empty, accept, rdata_ok, push, pop;
  logic bypass_hit, bypass_take;
  logic unused_low_bits;

  // The PC always presents byte addresses; reads are word aligned.
  assign unused_low_bits = ^pc_in[1:0];

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pc_stall = rst | (state != IDLE) | full;
  assign accept   = pc_valid & ~pc_stall;
  assign rdata_ok = (state == WAIT) & mem_rvalid & ~redirect;

`ifdef IFETCH_BYPASS_EN
  assign bypass_hit = rdata_ok & empty;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit & ir_ready;

  assign push = rdata_ok & ~bypass_take;
  assign pop  = ~redirect & ~empty & ir_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: redirect withdraws or dooms any read in progress.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (mem_gnt)       state_next = redirect ? DROP : WAIT;
        else if (redirect) state_next = IDLE;
      end
      WAIT: begin
        if (mem_rvalid)    state_next = IDLE;
        else if (redirect) state_next = DROP;
      end
      DROP: if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs derived from state and the FIFO head (or the bypassed word).
  always_comb begin
    mem_req  = (state == REQ);
    ir_valid = ~empty | bypass_hit;
    ir_instr = '0;
    ir_pc    = '0;
    if (!empty) begin
      ir_instr = fifo_instr[rd_ptr];
      ir_pc    = fifo_pc[rd_ptr];
    end else if (bypass_hit) begin
      ir_instr = mem_rdata;
      ir_pc    = mem_addr;
    end
    op     = ir_instr[31:26];
    offset = ir_instr[15:0];
    target = ir_instr[25:0];
  end

  // Latch the word-aligned fetch address when the PC hands one over.
  always_ff @(posedge clk) begin
    if (rst)         mem_addr <= '0;
    else if (accept) mem_addr <= {pc_in[ADDR_W-1:2], 2'b00};
  end

  // FIFO bookkeeping; a redirect empties the buffer and cancels same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are only visible while count is non-zero, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc[wr_ptr]    <= mem_addr;
      fifo_instr[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed stimulus for ifetch_unit with a transaction-level model
// (queue of fetched words plus the life of the single outstanding fetch) checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_ifetch_unit;
  localparam int FIFO_DEPTH = 2;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0, redirect = 1'b0;
  logic        pc_stall, mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_instr, ir_pc;
  logic [5:0]  op;
  logic [15:0] offset;
  logic [25:0] target;

  int n_cmp = 0;
  int n_bad = 0;

  ifetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .redirect(redirect),
    .pc_stall(pc_stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc), .op(op),
    .offset(offset), .target(target)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;
  ent_t q[$];
  // Life of the outstanding fetch: 0 none, 1 asking memory, 2 granted, 3 granted but unwanted.
  int          phase = 0;
  logic [31:0] m_addr = '0;
  bit          checking = 1'b0;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
    end
  endtask

  // Model update on each clock edge from the inputs as they stood at the edge.
  always @(posedge clk) begin : model
    bit stall, byp, hv, accept, arrive;
    stall  = (q.size() == FIFO_DEPTH) || (phase != 0);
    byp    = BYP && q.size() == 0 && phase == 2 && mem_rvalid && !redirect;
    hv     = q.size() > 0 || byp;
    accept = pc_valid && !stall;
    arrive = phase == 2 && mem_rvalid;
    if (rst) begin
      q.delete();
      phase  = 0;
      m_addr = '0;
      checking = 1'b1;
    end else begin
      if (redirect) q.delete();
      else begin
        if (hv && ir_ready && q.size() > 0) void'(q.pop_front());
        if (arrive && !(byp && ir_ready)) q.push_back('{m_addr, mem_rdata});
      end
      case (phase)
        0: if (accept) begin phase = 1; m_addr = pc_in & 32'hFFFF_FFFC; end
        1: if (mem_gnt) phase = redirect ? 3 : 2; else if (redirect) phase = 0;
        2: if (mem_rvalid) phase = 0; else if (redirect) phase = 3;
        default: if (mem_rvalid) phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model, mid-cycle.
  always @(negedge clk) begin : compare
    bit byp;
    logic [31:0] e_ins, e_pc;
    if (checking) begin
      byp   = BYP && !rst && q.size() == 0 && phase == 2 && mem_rvalid && !redirect;
      e_ins = q.size() > 0 ? q[0].ins : (byp ? mem_rdata : 32'h0);
      e_pc  = q.size() > 0 ? q[0].pc  : (byp ? m_addr : 32'h0);
      check_output("pc_stall", {31'b0, pc_stall}, {31'b0, rst || phase != 0 || q.size() == FIFO_DEPTH});
      check_output("mem_req",  {31'b0, mem_req}, {31'b0, phase == 1});
      check_output("mem_addr", mem_addr, m_addr);
      check_output("ir_valid", {31'b0, ir_valid}, {31'b0, q.size() > 0 || byp});
      check_output("ir_instr", ir_instr, e_ins);
      check_output("ir_pc",    ir_pc, e_pc);
      check_output("op",       {26'b0, op}, {26'b0, e_ins[31:26]});
      check_output("offset",   {16'b0, offset}, {16'b0, e_ins[15:0]});
      check_output("target",   {6'b0, target}, {6'b0, e_ins[25:0]});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] a);
    for (int i = 0; i < 20 && pc_stall; i++) cycle();
    if (pc_stall) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL stall_timeout: pc_stall still 1, required 0 within 20 cycles");
    end
    pc_valid = 1'b1;
    pc_in    = a;
    cycle();
    pc_valid = 1'b0;
  endtask

  task automatic grant();
    mem_gnt = 1'b1;
    cycle();
    mem_gnt = 1'b0;
  endtask

  task automatic ret(input logic [31:0] d);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    cycle();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic drain(input int n);
    ir_ready = 1'b1;
    repeat (n) cycle();
    ir_ready = 1'b0;
  endtask

  task automatic apply_stimulus();
    // Reset.
    cycle();
    check_output("lit_reset_stall", {31'b0, pc_stall}, 32'd1);
    cycle();
    rst = 1'b0;
    cycle();
    check_output("lit_post_reset_stall", {31'b0, pc_stall}, 32'd0);
    check_output("lit_reset_irvalid", {31'b0, ir_valid}, 32'd0);

    // Basic fetch: grant on first request cycle, data two cycles later.
    start_fetch(32'h0);
    check_output("lit_basic_req", {31'b0, mem_req}, 32'd1);
    check_output("lit_basic_addr", mem_addr, 32'h0);
    grant();
    cycle();
    ret(32'h0800_0010);
    check_output("lit_basic_valid", {31'b0, ir_valid}, 32'd1);
    check_output("lit_basic_pc", ir_pc, 32'h0);
    check_output("lit_basic_op", {26'b0, op}, 32'h02);
    check_output("lit_basic_target", {6'b0, target}, 32'h10);
    drain(1);

    // Back-pressure with a full FIFO.
    start_fetch(32'h4); grant(); ret(32'hA000_0004);
    start_fetch(32'h8); grant(); ret(32'hB000_0008);
    check_output("lit_full_stall", {31'b0, pc_stall}, 32'd1);
    check_output("lit_full_head", ir_pc, 32'h4);
    pc_valid = 1'b1;
    pc_in    = 32'hC;
    cycle();
    cycle();
    check_output("lit_full_noreq", {31'b0, mem_req}, 32'd0);
    ir_ready = 1'b1;
    #1;
    check_output("lit_full_pop_stall", {31'b0, pc_stall}, 32'd1);
    cycle();
    ir_ready = 1'b0;
    check_output("lit_order_second", ir_pc, 32'h8);
    cycle();
    pc_valid = 1'b0;
    check_output("lit_c_addr", mem_addr, 32'hC);
    grant(); ret(32'hC000_000C);
    ir_ready = 1'b1;
    cycle();
    check_output("lit_order_third", ir_pc, 32'hC);
    cycle();
    ir_ready = 1'b0;
    check_output("lit_drained", {31'b0, ir_valid}, 32'd0);

    // Grant stall for five cycles.
    start_fetch(32'h20);
    for (int i = 0; i < 5; i++) begin
      check_output("lit_gstall_req", {31'b0, mem_req}, 32'd1);
      check_output("lit_gstall_addr", mem_addr, 32'h20);
      check_output("lit_gstall_stall", {31'b0, pc_stall}, 32'd1);
      cycle();
    end
    grant(); ret(32'h2020_2020);

    // Redirect during WAIT with one entry queued.
    start_fetch(32'h10);
    grant();
    redirect = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h40;
    cycle();
    redirect = 1'b0;
    check_output("lit_flush_valid", {31'b0, ir_valid}, 32'd0);
    check_output("lit_drop_stall", {31'b0, pc_stall}, 32'd1);
    cycle();
    ret(32'h1000_0003);
    check_output("lit_dropped_valid", {31'b0, ir_valid}, 32'd0);
    check_output("lit_after_drop_stall", {31'b0, pc_stall}, 32'd0);
    cycle();
    pc_valid = 1'b0;
    check_output("lit_refetch_addr", mem_addr, 32'h40);
    grant(); ret(32'h0C00_0040);
    check_output("lit_refetch_pc", ir_pc, 32'h40);
    drain(1);

    // Misaligned address and decode fields.
    start_fetch(32'h16);
    check_output("lit_align_addr", mem_addr, 32'h14);
    grant(); ret(32'h1000_FFFE);
    check_output("lit_dec_op", {26'b0, op}, 32'h04);
    check_output("lit_dec_offset", {16'b0, offset}, 32'hFFFE);
    check_output("lit_dec_pc", ir_pc, 32'h14);

    // Reset while requesting with one entry queued.
    start_fetch(32'h30);
    rst = 1'b1;
    cycle();
    check_output("lit_rst_req", {31'b0, mem_req}, 32'd0);
    check_output("lit_rst_valid", {31'b0, ir_valid}, 32'd0);
    check_output("lit_rst_instr", ir_instr, 32'h0);
    check_output("lit_rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    #1;
    check_output("lit_rst_release_stall", {31'b0, pc_stall}, 32'd0);
    cycle();

    // Redirect in REQ without grant withdraws; target re-presented and accepted.
    start_fetch(32'h50);
    redirect = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h60;
    cycle();
    redirect = 1'b0;
    check_output("lit_withdraw_req", {31'b0, mem_req}, 32'd0);
    cycle();
    pc_valid = 1'b0;
    check_output("lit_withdraw_addr", mem_addr, 32'h60);
    grant(); ret(32'h6060_6060);

    // Redirect in IDLE flushes and accepts together.
    redirect = 1'b1;
    pc_valid = 1'b1;
    pc_in    = 32'h70;
    cycle();
    redirect = 1'b0;
    pc_valid = 1'b0;
    check_output("lit_idle_redir_valid", {31'b0, ir_valid}, 32'd0);
    check_output("lit_idle_redir_addr", mem_addr, 32'h70);
    grant(); ret(32'h7070_7070);
    drain(2);
  endtask

  initial begin
    apply_stimulus();
    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch responder between the program counter and instruction memory.
- Accepts each new word address from the PC and issues one memory read per address, with at most one read outstanding.
- Queues returned words, with their PCs, in a small FIFO for decode.
- Exposes the head instruction's op/offset/target fields back to the PC's jump/branch logic.
- Back-pressures the PC with pc_stall; on a redirect it flushes the FIFO and discards any in-flight read.

Parameters:
- FIFO_DEPTH, 2, number of instruction buffer entries (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, instruction width

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- pc_in  in  ADDR_W  fetch address from PC
- pc_valid  in  1  pc_in is a new fetch address
- redirect  in  1  jump/taken-branch: flush; pc_in carries the new target
- pc_stall  out  1  PC must hold; address not accepted
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  word-aligned read address
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- ir_valid  out  1  FIFO head valid
- ir_ready  in  1  consumer takes head this cycle
- ir_instr  out  DATA_W  head instruction
- ir_pc  out  ADDR_W  PC of head instruction
- op  out  6  ir_instr[31:26]
- offset  out  16  ir_instr[15:0]
- target  out  26  ir_instr[25:0]

Behaviour:
- Reset values:
  - state IDLE; FIFO count 0.
  - mem_req 0; mem_addr 0.
  - ir_valid 0; ir_instr, ir_pc, op, offset, target all 0.
  - pc_stall 1 during the reset cycle, 0 the cycle after.
- States:
  - IDLE: no read outstanding.
  - REQ: mem_req held high.
  - WAIT: granted, awaiting rvalid.
  - DROP: granted read is to be discarded.
- pc_stall (combinational) = rst | (state != IDLE) | (count == FIFO_DEPTH). A simultaneous pop does not relieve a full FIFO that cycle.
- Address accept: pc_valid & !pc_stall latches {pc_in[ADDR_W-1:2],2'b00} into mem_addr and moves to REQ. mem_req rises the next cycle (1-cycle latency); pc_in[1:0] is ignored.
- Request handshake:
  - REQ: mem_req=1 and mem_addr stable until mem_gnt.
  - REQ & mem_gnt -> WAIT; mem_req drops the cycle after grant.
- WAIT & mem_rvalid:
  - Push {mem_addr, mem_rdata} into the FIFO; -> IDLE.
  - ir_valid rises the next cycle if the FIFO was empty.
- FIFO:
  - Pop when ir_valid & ir_ready; a simultaneous push and pop keeps count unchanged.
  - A push is never attempted while full (guaranteed by pc_stall).
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Decode outputs: op/offset/target are slices of the head entry; all 0 when the FIFO is empty.
- Redirect (highest priority):
  - FIFO flushed: count=0, ir_valid=0 the next cycle; a same-cycle push or pop is cancelled.
  - IDLE: if pc_valid, pc_in is accepted the same cycle (flush and accept together).
  - REQ without mem_gnt: request withdrawn -> IDLE; redirect target not accepted (pc_stall was high); the PC re-presents it.
  - REQ with mem_gnt, or WAIT without mem_rvalid: -> DROP.
  - WAIT with mem_rvalid: data discarded -> IDLE.
  - DROP: the next mem_rvalid is discarded -> IDLE.
- Redirect while pc_valid=0: flush only.
- rst mid-operation returns to the reset state immediately. The memory is required to be reset by the same rst, so no orphaned rvalid follows.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, state is WAIT, and mem_rvalid is high, the word is presented the same cycle: ir_valid=1, ir_instr=mem_rdata, ir_pc=mem_addr, with decode fields from mem_rdata.
  - If ir_ready is also high, the word is consumed without being written to the FIFO.
  - Redirect in that cycle suppresses the bypass.
- Undefined: ir_valid is never combinational from memory; minimum rvalid-to-ir_valid latency is 1 cycle.

Test Plan:
- Basic fetch:
  - Stimulus: after reset, pc_in=0x00000000, pc_valid=1; mem_gnt on the first mem_req cycle; rvalid 2 cycles later with rdata=0x08000010.
  - Response: mem_addr=0x0; ir_valid=1, ir_pc=0x0, op=0x02, target=0x0000010 one cycle after rvalid (same cycle with IFETCH_BYPASS_EN).
- Back-pressure:
  - Stimulus: ir_ready=0; fetch pc 0x4 then 0x8 (FIFO_DEPTH=2).
  - Response: pc_stall stays 1 while full; pc_in=0xC not accepted until one ir_ready pop. FIFO order is 0x4 then 0x8.
- Grant stall:
  - Stimulus: mem_gnt held low 5 cycles.
  - Response: mem_req=1 and mem_addr constant for all 5 cycles; pc_stall=1 throughout.
- Redirect during WAIT:
  - Stimulus: fetch 0x10 granted, then redirect with pc_in=0x40 before rvalid; rvalid arrives with rdata=0x10000003.
  - Response: state goes to DROP and the word is discarded. The FIFO is empty with ir_valid=0 after the flush and the dropped word is never queued. 0x40 is fetched after the PC re-presents it.
- Misaligned address and decode:
  - Stimulus: pc_in=0x00000016; rdata=0x1000FFFE.
  - Response: mem_addr=0x00000014; op=0x04, offset=0xFFFE.
- Reset mid-fetch:
  - Stimulus: assert rst in REQ with the FIFO holding 1 entry.
  - Response: next cycle mem_req=0, ir_valid=0, all outputs 0, pc_stall=0 after rst falls.
